// File: rtl/mips_encode.sv
// ============================================================================
// Module      : mips_encode
// Description : Assembles 32-bit MIPS R/I-type arithmetic words from ALU
//               control fields and queues them in a valid/ready FIFO.
//               Optional macro MIPS_ENCODE_ERRCNT_EN adds a saturating
//               err_count output counting dropped illegal requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_encode #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    alu_op,
   input  logic          imm_form,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [15:0]   imm16,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic          err,
   output logic [AW:0]   count
`ifdef MIPS_ENCODE_ERRCNT_EN
   ,
   output logic [7:0]    err_count
`endif
);

   localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
   localparam logic [AW-1:0] c_ptr_one = AW'(1);

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_err;

   logic          w_legal;
   logic [5:0]    w_funct;
   logic [5:0]    w_opcode;
   logic [31:0]   w_word;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;

   // sub and nor have no immediate form; opcode stays 0 for them and is unused
   always_comb begin
      w_legal  = 1'b1;
      w_funct  = 6'h00;
      w_opcode = 6'h00;
      case (alu_op)
         3'b010: begin w_funct = 6'h20; w_opcode = 6'h08; end
         3'b011: begin w_funct = 6'h22; w_legal  = ~imm_form; end
         3'b100: begin w_funct = 6'h24; w_opcode = 6'h0C; end
         3'b101: begin w_funct = 6'h25; w_opcode = 6'h0D; end
         3'b110: begin w_funct = 6'h27; w_legal  = ~imm_form; end
         3'b111: begin w_funct = 6'h26; w_opcode = 6'h0E; end
         default: w_legal = 1'b0;
      endcase
      w_word = imm_form ? {w_opcode, rs, rt, imm16}
                        : {6'h00, rs, rt, rd, 5'h00, w_funct};
   end

   assign in_ready  = (r_count != c_full);
   assign out_valid = (r_count != '0);
   assign out_instr = r_mem[r_rd_ptr];
   assign count     = r_count;
   assign err       = r_err;

   assign w_accept = in_valid & in_ready;
   assign w_push   = w_accept & w_legal;
   assign w_pop    = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 32'h0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_err <= w_accept & ~w_legal;
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
            r_wr_ptr        <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef MIPS_ENCODE_ERRCNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err_count <= 8'h00;
      end else if (w_accept && !w_legal && r_err_count != 8'hFF) begin
         r_err_count <= r_err_count + 8'h01;
      end
   end

   assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire
